i2c_target_regs: RTL and testbench

I2C target (slave) that decodes bus transactions from a bit-banged or hardware I2C controller and turns them into a byte-wide register-access port for the dice design. Sits between the `uio` pad pins (SCL on `uio_in[3]`, SDA on `uio_in[2]`, SDA driven open-drain via the `uio_oe` path) and the project's configuration/result registers. Supports sub-addressed writes with auto-increment and, optionally, combined-format reads.

---
 rtl/i2c_pkg.sv | 32 +++
 rtl/i2c_target_regs_if.sv | 39 +++
 rtl/i2c_input_filter.sv | 71 +++++++
 rtl/i2c_target_regs.sv | 220 ++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// ============================================================================
// Module   : i2c_pkg
// Purpose  : Shared types and constants for the I2C register target.
//            Optional read states exist only with I2C_TARGET_READ_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

package i2c_pkg;

    localparam int   BYTE_W  = 8;
    localparam logic I2C_ACK = 1'b0;
    localparam logic I2C_NAK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_SUB       = 4'd3,
        ST_SUB_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
`ifdef I2C_TARGET_READ_EN
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
`endif
        ST_IGNORE    = 4'd9
    } state_e;

endpackage

`default_nettype wire

// File: rtl/i2c_target_regs_if.sv
// ============================================================================
// Module   : i2c_target_regs_if
// Purpose  : Byte-wide register access port between the I2C target and the
//            register file it serves.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface i2c_target_regs_if;
    import i2c_pkg::*;

    logic              wr_en;
    logic [BYTE_W-1:0] wr_addr;
    logic [BYTE_W-1:0] wr_data;
    logic [BYTE_W-1:0] rd_addr;
    logic [BYTE_W-1:0] rd_data;
    logic              busy;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        output busy,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        input  busy,
        output rd_data
    );

endinterface

`default_nettype wire

// File: rtl/i2c_input_filter.sv
// ============================================================================
// Module   : i2c_input_filter
// Purpose  : Two-flop synchronizer plus stability filter for one I2C line,
//            with single-cycle rise/fall pulses aligned to the level change.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [3:0] LAST_CNT = 4'(FILTER_LEN - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       level_q, level_d;
    logic       rise_q,  rise_d;
    logic       fall_q,  fall_d;
    logic [3:0] cnt_q,   cnt_d;

    // cnt_q counts consecutive synchronized samples that disagree with the
    // accepted level; any agreeing sample restarts the count.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cnt_d   = 4'd0;
        if (sync2_q != level_q) begin
            if (cnt_q == LAST_CNT) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            sync1_q <= pin_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

`default_nettype wire

// File: rtl/i2c_target_regs.sv
// ============================================================================
// Module   : i2c_target_regs
// Purpose  : I2C target turning sub-addressed bus writes (and, when
//            I2C_TARGET_READ_EN is defined, combined-format reads) into a
//            byte-wide register port with an auto-incrementing pointer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         FILTER_LEN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    i2c_target_regs_if.master regs
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_input_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk    (clk),
        .rst    (rst),
        .pin_in (scl_in),
        .level  (scl_lvl),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

    i2c_input_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk    (clk),
        .rst    (rst),
        .pin_in (sda_in),
        .level  (sda_lvl),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    state_e            state_q,   state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] shift_q,   shift_d;
    logic [BYTE_W-1:0] ptr_q,     ptr_d;
    logic              sda_oe_q,  sda_oe_d;
    logic              wr_en_q,   wr_en_d;
    logic [BYTE_W-1:0] wr_addr_q, wr_addr_d;
    logic [BYTE_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q,    busy_d;

    logic start_det;
    logic stop_det;
    logic byte_done;
    logic addr_ok;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign byte_done = scl_fall && (bit_cnt_q == 4'd8);

`ifdef I2C_TARGET_READ_EN
    assign addr_ok      = (shift_q[BYTE_W-1:1] == TARGET_ADDR);
    assign regs.rd_addr = ptr_q;
`else
    logic [BYTE_W-1:0] unused_rd_data;
    assign addr_ok        = (shift_q[BYTE_W-1:1] == TARGET_ADDR) && !shift_q[0];
    assign regs.rd_addr   = '0;
    assign unused_rd_data = regs.rd_data;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;

        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_SUB, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[BYTE_W-2:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (byte_done) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == ST_ADDR) begin
                            if (addr_ok) begin
                                state_d  = ST_ADDR_ACK;
                                sda_oe_d = ~I2C_ACK;
                            end else begin
                                state_d  = ST_IGNORE;
                            end
                        end else if (state_q == ST_SUB) begin
                            ptr_d    = shift_q;
                            state_d  = ST_SUB_ACK;
                            sda_oe_d = ~I2C_ACK;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = shift_q;
                            ptr_d     = ptr_q + 8'd1;
                            state_d   = ST_WDATA_ACK;
                            sda_oe_d  = ~I2C_ACK;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_SUB;
`ifdef I2C_TARGET_READ_EN
                        // R/W bit is still in the shift register's LSB.
                        if (shift_q[0]) begin
                            state_d  = ST_RDATA;
                            shift_d  = regs.rd_data;
                            sda_oe_d = ~regs.rd_data[BYTE_W-1];
                        end
`endif
                    end
                end

                ST_SUB_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WDATA;
                    end
                end

`ifdef I2C_TARGET_READ_EN
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (byte_done) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b0;
                        state_d   = ST_RDATA_ACK;
                    end else if (scl_fall) begin
                        shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
                        sda_oe_d = ~shift_q[BYTE_W-2];
                    end
                end

                // The shifted-out byte is spent, so its LSB holds the
                // controller's ACK/NAK until the closing SCL fall.
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        shift_d[0] = sda_lvl;
                        if (sda_lvl == I2C_ACK) begin
                            ptr_d = ptr_q + 8'd1;
                        end
                    end else if (scl_fall) begin
                        if (shift_q[0] == I2C_ACK) begin
                            state_d  = ST_RDATA;
                            shift_d  = regs.rd_data;
                            sda_oe_d = ~regs.rd_data[BYTE_W-1];
                        end else begin
                            state_d  = ST_IGNORE;
                        end
                    end
                end
`endif

                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign sda_oe       = sda_oe_q;
    assign regs.wr_en   = wr_en_q;
    assign regs.wr_addr = wr_addr_q;
    assign regs.wr_data = wr_data_q;
    assign regs.busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
// ============================================================================
// Module   : tb_i2c_target_regs
// Purpose  : Bit-banged I2C controller driving i2c_target_regs, checked
//            against a transaction-level register/pointer model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_i2c_target_regs;
    import i2c_pkg::*;

    localparam logic [6:0] TADDR = 7'h42;
    localparam int         Q     = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_drv = 1'b1;
    logic sda_drv_low = 1'b0;
    logic sda_oe;
    logic sda_line;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  regfile [256];
    logic [7:0]  m_ptr = 8'h00;
    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  tx_q[$];

    i2c_target_regs_if bus();

    assign sda_line    = ~(sda_drv_low | sda_oe);
    assign bus.rd_data = regfile[bus.rd_addr];

    i2c_target_regs #(.TARGET_ADDR(TADDR), .FILTER_LEN(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .scl_in (scl_drv),
        .sda_in (sda_line),
        .sda_oe (sda_oe),
        .regs   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.wr_en) obs_q.push_back({bus.wr_addr, bus.wr_data});
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period; SDA set mid-low, sampled late in the high phase.
    task automatic clock_bit(input logic b, input logic glitch, output logic seen);
        sda_drv_low = ~b;
        wait_clks(Q);
        scl_drv = 1'b1;
        wait_clks(Q / 2);
        if (glitch) begin
            scl_drv = 1'b0;
            wait_clks(2);
            scl_drv = 1'b1;
            wait_clks(Q / 2 - 2);
        end else begin
            wait_clks(Q / 2);
        end
        seen = sda_line;
        wait_clks(Q);
        scl_drv = 1'b0;
        wait_clks(Q);
    endtask

    task automatic send_start();
        sda_drv_low = 1'b0;
        wait_clks(Q);
        scl_drv = 1'b1;
        wait_clks(Q);
        sda_drv_low = 1'b1;
        wait_clks(Q);
        scl_drv = 1'b0;
        wait_clks(Q);
    endtask

    task automatic send_stop();
        sda_drv_low = 1'b1;
        wait_clks(Q);
        scl_drv = 1'b1;
        wait_clks(Q);
        sda_drv_low = 1'b0;
        wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic acked);
        logic seen;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], (i == glitch_bit), seen);
        clock_bit(1'b1, 1'b0, seen);
        acked = (seen == I2C_ACK);
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] d);
        logic seen;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, 1'b0, seen);
            d[i] = seen;
        end
        clock_bit(give_ack ? I2C_ACK : I2C_NAK, 1'b0, seen);
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, " wr_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, " wr_addr_data"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    // Full write transaction of tx_q bytes; the model decides ACKs and writes.
    task automatic write_txn(input logic [6:0] a7, input logic [7:0] sub,
                             input int sub_glitch, input string tag);
        logic hit;
        logic acked;
        hit = (a7 == TADDR);
        send_start();
        check({tag, " busy_start"}, bus.busy, 1'b1);
        write_byte({a7, 1'b0}, -1, acked);
        check({tag, " addr_ack"}, acked, hit);
        write_byte(sub, sub_glitch, acked);
        check({tag, " sub_ack"}, acked, hit);
        if (hit) m_ptr = sub;
        foreach (tx_q[i]) begin
            write_byte(tx_q[i], -1, acked);
            check({tag, " data_ack"}, acked, hit);
            if (hit) begin
                exp_q.push_back({m_ptr, tx_q[i]});
                m_ptr = m_ptr + 8'd1;
            end
        end
        send_stop();
        wait_clks(Q);
        check({tag, " busy_stop"}, bus.busy, 1'b0);
        compare_writes(tag);
        tx_q.delete();
    endtask

    initial begin
        logic       acked;
        logic [7:0] d;
        logic [6:0] a7;
        logic [7:0] sub;
        int         n;

        for (int i = 0; i < 256; i++) regfile[i] = 8'($urandom);

        wait_clks(5);
        check("rst sda_oe", sda_oe, 1'b0);
        check("rst wr_en", bus.wr_en, 1'b0);
        check("rst wr_addr", bus.wr_addr, 8'h00);
        check("rst wr_data", bus.wr_data, 8'h00);
        check("rst rd_addr", bus.rd_addr, 8'h00);
        check("rst busy", bus.busy, 1'b0);
        rst = 1'b0;
        wait_clks(Q);

        tx_q = '{8'hA5, 8'h3C};
        write_txn(7'h42, 8'h10, -1, "basic");

        tx_q = '{8'h55, 8'h66};
        write_txn(7'h43, 8'h10, -1, "mismatch");

        tx_q = '{8'h11, 8'h22};
        write_txn(7'h42, 8'hFF, -1, "wrap");

        tx_q = '{8'h99};
        write_txn(7'h42, 8'h5C, 3, "glitch");

        for (int k = 0; k < 6; k++) begin
            a7 = TADDR;
            if ($urandom_range(0, 3) == 0) begin
                a7 = 7'($urandom);
                if (a7 == TADDR) a7 = a7 ^ 7'h01;
            end
            sub = 8'($urandom);
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
            write_txn(a7, sub, -1, "rand_wr");
        end

        // Reset in the middle of a data byte (SCL low, SDA released).
        send_start();
        write_byte(8'h84, -1, acked);
        write_byte(8'h30, -1, acked);
        for (int i = 0; i < 4; i++) clock_bit(1'b1, 1'b0, acked);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst sda_oe", sda_oe, 1'b0);
        check("midrst busy", bus.busy, 1'b0);
        check("midrst wr_addr", bus.wr_addr, 8'h00);
        check("midrst wr_data", bus.wr_data, 8'h00);
        rst = 1'b0;
        m_ptr = 8'h00;
        wait_clks(Q);
        for (int i = 0; i < 4; i++) clock_bit(1'b0, 1'b0, acked);
        clock_bit(1'b1, 1'b0, acked);
        check("midrst ack", acked, I2C_NAK);
        write_byte(8'h77, -1, acked);
        check("midrst next_ack", acked, 1'b0);
        send_stop();
        wait_clks(Q);
        compare_writes("midrst");

`ifdef I2C_TARGET_READ_EN
        regfile[8'h20] = 8'h5A;
        regfile[8'h21] = 8'hC3;
        send_start();
        write_byte(8'h84, -1, acked);
        write_byte(8'h20, -1, acked);
        m_ptr = 8'h20;
        send_start();
        write_byte(8'h85, -1, acked);
        check("rd addr_ack", acked, 1'b1);
        read_byte(1'b1, d);
        check("rd byte0", d, 8'h5A);
        read_byte(1'b0, d);
        check("rd byte1", d, 8'hC3);
        m_ptr = 8'h21;
        check("rd sda_oe_after_nak", sda_oe, 1'b0);
        send_stop();
        wait_clks(Q);
        compare_writes("rd");

        for (int k = 0; k < 3; k++) begin
            sub = 8'($urandom);
            n = $urandom_range(1, 3);
            send_start();
            write_byte(8'h84, -1, acked);
            write_byte(sub, -1, acked);
            m_ptr = sub;
            send_start();
            write_byte(8'h85, -1, acked);
            check("rrd addr_ack", acked, 1'b1);
            for (int j = 0; j < n; j++) begin
                read_byte(j != n - 1, d);
                check("rrd data", d, regfile[m_ptr]);
                if (j != n - 1) m_ptr = m_ptr + 8'd1;
            end
            send_stop();
            wait_clks(Q);
            // Plain read continues from the retained pointer.
            send_start();
            write_byte(8'h85, -1, acked);
            read_byte(1'b0, d);
            check("rrd retained", d, regfile[m_ptr]);
            send_stop();
            wait_clks(Q);
            compare_writes("rrd");
        end
`else
        send_start();
        write_byte(8'h84, -1, acked);
        write_byte(8'h20, -1, acked);
        send_start();
        write_byte(8'h85, -1, acked);
        check("rd_dis addr_nak", acked, 1'b0);
        read_byte(1'b0, d);
        check("rd_dis bus_idle", d, 8'hFF);
        check("rd_dis sda_oe", sda_oe, 1'b0);
        send_stop();
        wait_clks(Q);
        compare_writes("rd_dis");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
